// File: rtl/fp_mult_axil_slave.sv
// AXI4-Lite register front-end for the single-precision FP multiplier core.
// Holds OPA/OPB/CTRL/RESULT, launches the core and raises a level completion interrupt.
module fp_mult_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     mult_a,
  output logic [31:0]                     mult_b,
  output logic                            mult_start,
  input  logic                            mult_valid,
  input  logic [31:0]                     mult_result,
  output logic                            irq
);

  typedef enum logic [1:0] {
    REG_OPA    = 2'd0,
    REG_OPB    = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RESULT = 2'd3
  } reg_sel_e;

  logic        ready_en_q;
  logic        aw_q;
  reg_sel_e    aw_sel_q;
  logic        w_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q;
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] opa_q, opb_q, result_q;
  logic [31:0] mult_a_q, mult_b_q;
  logic        busy_q, done_q, irq_en_q, start_q;

  logic aw_hs, w_hs, ar_hs, wr_commit;

  // Readies held low until one cycle after reset so they read 0 while ARESET is applied.
  assign S_AXI_AWREADY = ready_en_q & ~aw_q & ~bvalid_q;
  assign S_AXI_WREADY  = ready_en_q & ~w_q & ~bvalid_q;
  assign S_AXI_ARREADY = ready_en_q & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign mult_a        = mult_a_q;
  assign mult_b        = mult_b_q;
  assign mult_start    = start_q;
  assign irq           = done_q & irq_en_q;

  assign aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
  assign wr_commit = aw_q & w_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rdata_d = '0;
    unique case (reg_sel_e'(S_AXI_ARADDR[3:2]))
      REG_OPA:    rdata_d = opa_q;
      REG_OPB:    rdata_d = opb_q;
      REG_CTRL:   rdata_d = {28'd0, irq_en_q, done_q, busy_q, 1'b0};
      REG_RESULT: rdata_d = result_q;
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ready_en_q <= 1'b0;
      aw_q       <= 1'b0;
      aw_sel_q   <= REG_OPA;
      w_q        <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      mult_a_q   <= '0;
      mult_b_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      start_q    <= 1'b0;

      if (aw_hs) begin
        aw_q     <= 1'b1;
        aw_sel_q <= reg_sel_e'(S_AXI_AWADDR[3:2]);
      end
      if (w_hs) begin
        w_q      <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;

      if (wr_commit) begin
        aw_q     <= 1'b0;
        w_q      <= 1'b0;
        bvalid_q <= 1'b1;
        unique case (aw_sel_q)
          REG_OPA: opa_q <= merge_bytes(opa_q, w_data_q, w_strb_q);
          REG_OPB: opb_q <= merge_bytes(opb_q, w_data_q, w_strb_q);
          REG_CTRL: begin
            if (w_strb_q[0]) begin
              irq_en_q <= w_data_q[3];
              if (w_data_q[2]) done_q <= 1'b0;
              if (w_data_q[0] && !busy_q) begin
                mult_a_q <= opa_q;
                mult_b_q <= opb_q;
                start_q  <= 1'b1;
                busy_q   <= 1'b1;
                done_q   <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end

      // Placed after the CTRL write so a completion beats a same-cycle DONE clear.
      if (mult_valid && busy_q) begin
        result_q <= mult_result;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
      end

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule
